// File: rtl/rv_mini_pkg.sv
// Shared encodings for the 16-bit mini RISC-V core and its program sequencer.
// Opcode sits in [1:0], funct3 in [15:13]; halt is an O-type ALUOUT with [12:11] = 11.
package rv_mini_pkg;

    localparam logic [1:0]  OPC_R     = 2'b00;
    localparam logic [1:0]  OPC_I     = 2'b01;
    localparam logic [1:0]  OPC_L     = 2'b10;
    localparam logic [1:0]  OPC_O     = 2'b11;

    localparam logic [2:0]  F3_OUT    = 3'b000;
    localparam logic [2:0]  F3_CMP    = 3'b011;
    localparam logic [2:0]  F3_ALUOUT = 3'b111;

    // L-type, so the core never writes a register while idling on it.
    localparam logic [15:0] NOP_INSTR = {14'h0000, OPC_L};

    localparam logic [2:0]  HALT_F3   = F3_ALUOUT;
    localparam logic [1:0]  HALT_SUB  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } seq_state_e;

    function automatic logic is_halt(input logic [15:0] instr);
        return (instr[1:0] == OPC_O) && (instr[15:13] == HALT_F3) &&
               (instr[12:11] == HALT_SUB);
    endfunction

    function automatic logic is_cmp(input logic [15:0] instr);
        return (instr[1:0] == OPC_O) && (instr[15:13] == F3_CMP);
    endfunction

    function automatic logic is_capture(input logic [15:0] instr);
        return (instr[1:0] == OPC_O) &&
               ((instr[15:13] == F3_OUT) ||
                ((instr[15:13] == F3_ALUOUT) && !instr[12]));
    endfunction

    function automatic logic is_r_or_i(input logic [15:0] instr);
        return (instr[1:0] == OPC_R) || (instr[1:0] == OPC_I);
    endfunction

endpackage

// File: rtl/instr_sequencer_if.sv
// Bus between the program sequencer and its environment (loader, control, core).
// The slave side is the sequencer; the master side drives loads, control and core_result.
interface instr_sequencer_if #(
    parameter int AW = 4
);
    logic          ld_valid;
    logic [7:0]    ld_byte;
    logic          start;
    logic          hold;
    logic          abort;
    logic [7:0]    core_result;
    logic [15:0]   instr_out;
    logic [AW:0]   pc_out;
    logic          busy;
    logic          done;
    logic          out_valid;
    logic [7:0]    out_data;
    logic          ld_overflow;
    logic [AW:0]   prog_len;

    modport master (
        output ld_valid, ld_byte, start, hold, abort, core_result,
        input  instr_out, pc_out, busy, done, out_valid, out_data, ld_overflow, prog_len
    );

    modport slave (
        input  ld_valid, ld_byte, start, hold, abort, core_result,
        output instr_out, pc_out, busy, done, out_valid, out_data, ld_overflow, prog_len
    );
endinterface

// File: rtl/instr_store.sv
// Instruction store: assembles byte pairs (low byte first) into 16-bit words,
// appends them at prog_len, and exposes an asynchronous read port for the sequencer.
module instr_store
    import rv_mini_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_wr_en,
    input  logic [7:0]    i_byte,
    input  logic [AW-1:0] i_rd_addr,
    output logic [15:0]   o_rd_data,
    output logic [AW:0]   o_prog_len,
    output logic          o_overflow
);

    localparam logic [AW:0] FULL_LEN = (AW + 1)'(DEPTH);

    logic [15:0] r_mem [DEPTH];
    logic [7:0]  r_lo;
    logic        r_toggle;
    logic [AW:0] r_len;
    logic        r_ovf;
    logic        w_full;

    assign w_full = (r_len == FULL_LEN);

    // Once full, every further byte is dropped and flagged; the toggle is frozen.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= NOP_INSTR;
            end
            r_lo     <= 8'h00;
            r_toggle <= 1'b0;
            r_len    <= '0;
            r_ovf    <= 1'b0;
        end else if (i_wr_en) begin
            if (w_full) begin
                r_ovf <= 1'b1;
            end else if (!r_toggle) begin
                r_lo     <= i_byte;
                r_toggle <= 1'b1;
            end else begin
                r_mem[r_len[AW-1:0]] <= {i_byte, r_lo};
                r_len    <= r_len + 1'b1;
                r_toggle <= 1'b0;
            end
        end
    end

    assign o_rd_data  = r_mem[i_rd_addr];
    assign o_prog_len = r_len;
    assign o_overflow = r_ovf;

endmodule

// File: rtl/instr_sequencer.sv
// Program sequencer: issues one stored instruction per unheld RUN cycle, steers the PC
// on halt/compare results, and captures core output for output-class instructions.
module instr_sequencer
    import rv_mini_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    instr_sequencer_if.slave   bus
);

    seq_state_e  r_state;
    logic [AW:0] r_pc;
    logic [15:0] r_instr;
    logic        r_issued;
    logic        r_out_valid;
    logic [7:0]  r_out_data;

    seq_state_e  w_state_next;
    logic [AW:0] w_pc_next;
    logic [AW:0] w_pc_step;
    logic [15:0] w_instr_next;
    logic        w_issued_next;
    logic        w_out_valid_next;
    logic [7:0]  w_out_data_next;
    logic [15:0] w_rd_data;
    logic [AW:0] w_prog_len;
    logic        w_overflow;
    logic        w_ld_en;

    assign w_ld_en = bus.ld_valid && (r_state != ST_RUN);

    instr_store #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_store (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_wr_en    (w_ld_en),
        .i_byte     (bus.ld_byte),
        .i_rd_addr  (w_pc_next[AW-1:0]),
        .o_rd_data  (w_rd_data),
        .o_prog_len (w_prog_len),
        .o_overflow (w_overflow)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_pc        <= '0;
            r_instr     <= NOP_INSTR;
            r_issued    <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_data  <= 8'h00;
        end else begin
            r_state     <= w_state_next;
            r_pc        <= w_pc_next;
            r_instr     <= w_instr_next;
            r_issued    <= w_issued_next;
            r_out_valid <= w_out_valid_next;
            r_out_data  <= w_out_data_next;
        end
    end

    // r_instr is what the core executes this cycle; r_issued marks it as a real
    // issue (not a hold/idle NOP), so its effect on PC and capture lands at this edge.
    always_comb begin
        w_state_next     = r_state;
        w_pc_next        = r_pc;
        w_pc_step        = r_pc + ((is_cmp(r_instr) && bus.core_result[0]) ? 2'd2 : 2'd1);
        w_instr_next     = NOP_INSTR;
        w_issued_next    = 1'b0;
        w_out_valid_next = 1'b0;
        w_out_data_next  = r_out_data;

        if (bus.abort) begin
            w_state_next = ST_IDLE;
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    if (bus.start && (w_prog_len != '0)) begin
                        w_state_next = ST_RUN;
                        w_pc_next    = '0;
                    end
                end
                ST_RUN: begin
                    if (r_issued) begin
                        if (is_halt(r_instr)) begin
                            w_state_next = ST_HALT;
                        end else begin
                            w_pc_next = w_pc_step;
                            if (w_pc_step >= w_prog_len) begin
                                w_state_next = ST_HALT;
                            end
                        end
                        if (is_capture(r_instr)) begin
                            w_out_valid_next = 1'b1;
                            w_out_data_next  = bus.core_result;
                        end
                    end
                end
                ST_HALT: begin
                    if (bus.start) begin
                        w_state_next = ST_IDLE;
                    end
                end
                default: w_state_next = ST_IDLE;
            endcase
        end

        if ((w_state_next == ST_RUN) && !bus.hold) begin
            w_instr_next  = w_rd_data;
            w_issued_next = 1'b1;
        end
    end

    assign bus.instr_out   = r_instr;
    assign bus.pc_out      = r_pc;
    assign bus.busy        = (r_state == ST_RUN);
    assign bus.done        = (r_state == ST_HALT);
    assign bus.out_valid   = r_out_valid;
    assign bus.out_data    = r_out_data;
    assign bus.ld_overflow = w_overflow;
    assign bus.prog_len    = w_prog_len;

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed bench for instr_sequencer: scoreboard queues hold the expected issue stream
// and captured results; a tiny core model answers OUT and CMP instructions.
module tb_instr_sequencer;

    localparam int DEPTH = 16;
    localparam int AW    = 4;
    localparam logic [15:0] NOP = 16'h0002;

    logic clk;
    logic rst_n;
    logic cmp_bit;
    int   checks;
    int   errors;

    logic [15:0] exp_instr [$];
    logic [AW:0] exp_pc    [$];
    logic [7:0]  exp_out   [$];

    instr_sequencer_if #(.AW(AW)) bus ();

    instr_sequencer #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Core model: OUT r1 yields 5, CMP yields the selected compare bit.
    always_comb begin
        bus.core_result = 8'h00;
        if (bus.instr_out == 16'h0023) begin
            bus.core_result = 8'h05;
        end else if ((bus.instr_out[1:0] == 2'b11) && (bus.instr_out[15:13] == 3'b011)) begin
            bus.core_result = {7'b0, cmp_bit};
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load_instr(input logic [15:0] w);
        bus.ld_valid = 1'b1;
        bus.ld_byte  = w[7:0];
        step();
        bus.ld_byte  = w[15:8];
        step();
        bus.ld_valid = 1'b0;
    endtask

    task automatic push_issue(input logic [15:0] w, input int pc);
        exp_instr.push_back(w);
        exp_pc.push_back(pc[AW:0]);
    endtask

    task automatic run_collect(input string tag);
        bit          fin;
        logic [15:0] ei;
        logic [AW:0] ep;
        logic [7:0]  eo;
        fin = 1'b0;
        for (int n = 0; n < 80; n++) begin
            if (bus.busy && (bus.instr_out !== NOP)) begin
                check({tag, "_issue_expected"}, 32'(exp_instr.size() != 0), 32'd1);
                if (exp_instr.size() != 0) begin
                    ei = exp_instr.pop_front();
                    ep = exp_pc.pop_front();
                    check({tag, "_instr"}, 32'(bus.instr_out), 32'(ei));
                    check({tag, "_pc"}, 32'(bus.pc_out), 32'(ep));
                    $display("%s issue instr=%h pc=%0d", tag, bus.instr_out, bus.pc_out);
                end
            end
            if (bus.out_valid) begin
                check({tag, "_out_expected"}, 32'(exp_out.size() != 0), 32'd1);
                if (exp_out.size() != 0) begin
                    eo = exp_out.pop_front();
                    check({tag, "_out_data"}, 32'(bus.out_data), 32'(eo));
                    $display("%s output data=%h", tag, bus.out_data);
                end
            end
            if (bus.done) begin
                fin = 1'b1;
                break;
            end
            step();
        end
        check({tag, "_reached_halt"}, 32'(fin), 32'd1);
        check({tag, "_issue_left"}, 32'(exp_instr.size()), 32'd0);
        check({tag, "_out_left"}, 32'(exp_out.size()), 32'd0);
        check({tag, "_post_instr"}, 32'(bus.instr_out), 32'(NOP));
        check({tag, "_post_busy"}, 32'(bus.busy), 32'd0);
    endtask

    task automatic load_cmp_prog();
        load_instr(16'h6003);
        load_instr(16'h0506);
        load_instr(16'h0023);
        load_instr(16'hF803);
    endtask

    // From HALT: first start returns to IDLE, second launches the run.
    task automatic restart_from_halt();
        bus.start = 1'b1;
        step();
        step();
        bus.start = 1'b0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        cmp_bit = 1'b0;
        rst_n = 1'b0;
        bus.ld_valid = 1'b0;
        bus.ld_byte  = 8'h00;
        bus.start    = 1'b0;
        bus.hold     = 1'b0;
        bus.abort    = 1'b0;

        // Reset values
        repeat (2) @(posedge clk);
        #1;
        check("rst_instr", 32'(bus.instr_out), 32'(NOP));
        check("rst_pc", 32'(bus.pc_out), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_out_data", 32'(bus.out_data), 32'd0);
        check("rst_ovf", 32'(bus.ld_overflow), 32'd0);
        check("rst_len", 32'(bus.prog_len), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step();

        // LI r1,5; OUT r1; HALT
        load_instr(16'h0506);
        load_instr(16'h0023);
        load_instr(16'hF803);
        check("t1_len", 32'(bus.prog_len), 32'd3);
        push_issue(16'h0506, 0);
        push_issue(16'h0023, 1);
        push_issue(16'hF803, 2);
        exp_out.push_back(8'h05);
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        run_collect("t1");
        check("t1_done", 32'(bus.done), 32'd1);
        check("t1_pc_final", 32'(bus.pc_out), 32'd2);

        // Compare taken: LI skipped
        rst_n = 1'b0;
        #1;
        @(negedge clk);
        rst_n = 1'b1;
        step();
        load_cmp_prog();
        cmp_bit = 1'b1;
        push_issue(16'h6003, 0);
        push_issue(16'h0023, 2);
        push_issue(16'hF803, 3);
        exp_out.push_back(8'h05);
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        run_collect("t2");
        check("t2_pc_final", 32'(bus.pc_out), 32'd3);

        // Compare not taken: all four issue
        cmp_bit = 1'b0;
        restart_from_halt();
        push_issue(16'h6003, 0);
        push_issue(16'h0506, 1);
        push_issue(16'h0023, 2);
        push_issue(16'hF803, 3);
        exp_out.push_back(8'h05);
        run_collect("t3");
        check("t3_pc_final", 32'(bus.pc_out), 32'd3);

        // Hold for three edges after the first instruction
        restart_from_halt();
        check("t4_first_instr", 32'(bus.instr_out), 32'h6003);
        check("t4_first_pc", 32'(bus.pc_out), 32'd0);
        bus.hold = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            check("t4_hold_instr", 32'(bus.instr_out), 32'(NOP));
            check("t4_hold_pc", 32'(bus.pc_out), 32'd1);
            check("t4_hold_busy", 32'(bus.busy), 32'd1);
            $display("t4 hold cycle %0d instr=%h pc=%0d", k, bus.instr_out, bus.pc_out);
        end
        bus.hold = 1'b0;
        step();
        push_issue(16'h0506, 1);
        push_issue(16'h0023, 2);
        push_issue(16'hF803, 3);
        exp_out.push_back(8'h05);
        run_collect("t4");

        // Abort mid-run, then async reset mid-run
        restart_from_halt();
        step();
        bus.abort = 1'b1;
        bus.start = 1'b1;
        step();
        bus.abort = 1'b0;
        bus.start = 1'b0;
        check("t5_abort_instr", 32'(bus.instr_out), 32'(NOP));
        check("t5_abort_busy", 32'(bus.busy), 32'd0);
        check("t5_abort_done", 32'(bus.done), 32'd0);
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        check("t5_rerun_busy", 32'(bus.busy), 32'd1);
        check("t5_rerun_instr", 32'(bus.instr_out), 32'h6003);
        step();
        #2;
        rst_n = 1'b0;
        #1;
        check("t5_rst_instr", 32'(bus.instr_out), 32'(NOP));
        check("t5_rst_busy", 32'(bus.busy), 32'd0);
        check("t5_rst_done", 32'(bus.done), 32'd0);
        check("t5_rst_len", 32'(bus.prog_len), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        step();
        check("t5_empty_start_busy", 32'(bus.busy), 32'd0);
        check("t5_empty_start_instr", 32'(bus.instr_out), 32'(NOP));
        $display("t5 abort/reset instr=%h busy=%0d", bus.instr_out, bus.busy);

        // Overflow: DEPTH words plus two dropped bytes, program runs off the end
        for (int i = 0; i < DEPTH; i++) begin
            load_instr(16'h1000 + 16'(i << 4));
        end
        check("t6_len_before", 32'(bus.prog_len), 32'(DEPTH));
        check("t6_ovf_before", 32'(bus.ld_overflow), 32'd0);
        load_instr(16'hFFFF);
        check("t6_len", 32'(bus.prog_len), 32'(DEPTH));
        check("t6_ovf", 32'(bus.ld_overflow), 32'd1);
        for (int i = 0; i < DEPTH; i++) begin
            push_issue(16'h1000 + 16'(i << 4), i);
        end
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        run_collect("t6");
        check("t6_pc_final", 32'(bus.pc_out), 32'(DEPTH));
        check("t6_ovf_sticky", 32'(bus.ld_overflow), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
